pu_or1k_spr_master: RTL and testbench
=====================================

PU_OR1K_SPR_MASTER -- requirements
Module: pu_or1k_spr_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: cycles in ACCESS without spr_bus_ack_i before abort (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cmd_valid_i  input  1  command offered.
REQ-005 SHALL have port cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high at a clock edge.
REQ-006 SHALL have port cmd_we_i  input  1  1 = SPR write, 0 = SPR read.
REQ-007 SHALL have port cmd_addr_i  input  16  first SPR address; [15:11] group, [10:0] offset.
REQ-008 SHALL have port cmd_dat_i  input  32  write data.
REQ-009 SHALL have port cmd_len_i  input  3  words minus one; honoured for reads only, writes are always single-word.
REQ-010 SHALL have port rsp_valid_o  output  1  response word available.
REQ-011 SHALL have port rsp_ready_i  input  1  response consumed when rsp_valid_o and rsp_ready_i are both high at a clock edge.
REQ-012 SHALL have port rsp_dat_o  output  32  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err_o  output  1  timeout on this word.
REQ-014 SHALL have port rsp_last_o  output  1  final response of the command.
REQ-015 SHALL have port spr_access_o  output  1  SPR access strobe.
REQ-016 SHALL have port spr_we_o  output  1  write qualifier.
REQ-017 SHALL have port spr_re_o  output  1  read qualifier.
REQ-018 SHALL have port spr_addr_o  output  16  SPR address.
REQ-019 SHALL have port spr_dat_o  output  32  SPR write data.
REQ-020 SHALL have port spr_bus_ack_i  input  1  slave acknowledge; responders may ack combinationally in the same cycle.
REQ-021 SHALL have port spr_dat_i  input  32  slave read data, valid when spr_bus_ack_i is high.

Function
REQ-022 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-023 cmd_ready_o SHALL be high exactly when the state is IDLE.
REQ-024 On command acceptance the FSM SHALL move IDLE->ACCESS, latch we/addr/dat/len, and clear the word counter and the timeout counter.
REQ-025 In ACCESS, spr_access_o SHALL be 1, spr_we_o SHALL equal the latched we, spr_re_o SHALL equal its inverse, and spr_addr_o/spr_dat_o SHALL be held stable.
REQ-026 Outside ACCESS, spr_access_o, spr_we_o and spr_re_o SHALL be 0, and spr_bus_ack_i SHALL be ignored.
REQ-027 On an ACCESS cycle with spr_bus_ack_i=1, the FSM SHALL capture spr_dat_i (reads) or 0 (writes) into rsp_dat_o, set rsp_err_o=0, and go to RESP.
REQ-028 Each ACCESS cycle without ack SHALL increment the 8-bit timeout counter.
REQ-029 When an ACCESS cycle without ack reaches a counter value of TIMEOUT-1, the FSM SHALL go to RESP with rsp_err_o=1, rsp_dat_o=0 and rsp_last_o=1, and SHALL abort the remaining burst words.
REQ-030 Minimum latency SHALL be: command accepted at edge N, spr_access_o high in cycle N+1, rsp_valid_o high in cycle N+2 for a same-cycle ack.
REQ-031 In RESP, rsp_valid_o SHALL be 1 and rsp_dat_o/rsp_err_o/rsp_last_o SHALL be held until the handshake completes; backpressure SHALL be unbounded.
REQ-032 rsp_last_o SHALL be 1 when the word counter equals the latched len, or on error.
REQ-033 On the RESP handshake: if rsp_last_o=1 the FSM SHALL go to IDLE; otherwise it SHALL increment the word counter, advance the address, clear the timeout counter and go to ACCESS.
REQ-034 Address advance SHALL be offset[10:0]+1 modulo 2^11, with group[15:11] unchanged, so 0x07FF wraps to 0x0000 and 0x27FF wraps to 0x2000.
REQ-035 A command presented while the state is not IDLE SHALL NOT be accepted and SHALL NOT disturb the transfer in progress.

Reset
REQ-036 While rst is high, the state SHALL be IDLE, all counters 0, and every output 0 except cmd_ready_o.
REQ-037 cmd_ready_o SHALL be 1 from the first edge after rst deasserts.
REQ-038 A reset asserted mid-burst SHALL drop spr_access_o and rsp_valid_o immediately (asynchronously) and SHALL produce no further response for that command.

Verification
REQ-039 Single read of 0x7800, slave acks same cycle with 0x0000_1234 -> spr_re_o=1 for exactly one cycle; response dat=0x1234, err=0, last=1 one cycle later.
REQ-040 Write 0x0000_0401 to 0x7808, ack delayed 3 cycles -> spr_we_o/spr_dat_o held stable 4 cycles; response dat=0, err=0, last=1.
REQ-041 Burst read at 0x7800, len=7, rsp_ready_i toggling -> exactly 8 accesses on addresses 0x7800..0x7807, 8 responses in order, last=1 on the 8th only.
REQ-042 No ack with TIMEOUT=15 on a len=3 read -> spr_access_o high exactly 15 cycles; one response with err=1, dat=0, last=1; cmd_ready_o=1 after the handshake.
REQ-043 Burst read at 0x27FE, len=2 -> accesses on 0x27FE, 0x27FF, 0x2000.
REQ-044 rst pulsed during the 2nd word of a burst -> outputs return to reset values at once; a new command is accepted normally after release.

Source files
------------

// File: rtl/pu_or1k_spr_master.sv
// ============================================================================
// Module      : pu_or1k_spr_master
// Description : Command-driven OR1K SPR bus master with read bursts, address
//               auto-increment within the SPR group and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_or1k_spr_master #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [15:0] cmd_addr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [2:0]  cmd_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic        spr_re_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_dat;
    logic [2:0]  r_len;
    logic [2:0]  r_wcnt;
    logic [7:0]  r_tcnt;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic        r_rsp_last;
    logic        w_expire;

    assign w_expire = !spr_bus_ack_i && (r_tcnt == c_to_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid_i) w_next = S_ACCESS;
            S_ACCESS: if (spr_bus_ack_i || w_expire) w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready_i) w_next = r_rsp_last ? S_IDLE : S_ACCESS;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= 16'h0;
            r_dat      <= 32'h0;
            r_len      <= 3'd0;
            r_wcnt     <= 3'd0;
            r_tcnt     <= 8'd0;
            r_rsp_dat  <= 32'h0;
            r_rsp_err  <= 1'b0;
            r_rsp_last <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_we   <= cmd_we_i;
                        r_addr <= cmd_addr_i;
                        r_dat  <= cmd_dat_i;
                        // Writes are single-word regardless of the requested length
                        r_len  <= cmd_we_i ? 3'd0 : cmd_len_i;
                        r_wcnt <= 3'd0;
                        r_tcnt <= 8'd0;
                    end
                end
                S_ACCESS: begin
                    if (spr_bus_ack_i) begin
                        r_rsp_dat  <= r_we ? 32'h0 : spr_dat_i;
                        r_rsp_err  <= 1'b0;
                        r_rsp_last <= (r_wcnt == r_len);
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (w_expire) begin
                            r_rsp_dat  <= 32'h0;
                            r_rsp_err  <= 1'b1;
                            r_rsp_last <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i && !r_rsp_last) begin
                        r_wcnt <= r_wcnt + 3'd1;
                        // Offset wraps inside the 2K group; group bits never change
                        r_addr <= {r_addr[15:11], r_addr[10:0] + 11'd1};
                        r_tcnt <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o  = (r_state == S_IDLE);
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_err_o    = r_rsp_err;
    assign rsp_last_o   = r_rsp_last;
    assign spr_access_o = (r_state == S_ACCESS);
    assign spr_we_o     = spr_access_o && r_we;
    assign spr_re_o     = spr_access_o && !r_we;
    assign spr_addr_o   = r_addr;
    assign spr_dat_o    = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_pu_or1k_spr_master.sv
// ============================================================================
// Module      : tb_pu_or1k_spr_master
// Description : Table-driven self-checking bench with response/address
//               scoreboards and a configurable-latency SPR slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pu_or1k_spr_master;

    localparam int c_timeout = 15;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] dat;
        logic [2:0]  len;
        int          delay;
        bit          noack;
        int          rmode;
        logic [15:0] hi;
        int          exp_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [15:0] cmd_addr_i = 16'h0;
    logic [31:0] cmd_dat_i = 32'h0;
    logic [2:0]  cmd_len_i = 3'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_last_o;
    logic        spr_access_o;
    logic        spr_we_o;
    logic        spr_re_o;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_dat_o;
    logic        spr_bus_ack_i;
    logic [31:0] spr_dat_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          s_delay = 0;
    bit          s_noack = 1'b0;
    logic [15:0] s_hi = 16'h0;
    int          rmode = 0;
    int          acc_cnt;
    int          acc_cycles = 0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_dat = 32'h0;
    logic [15:0] exp_addr[$];
    logic [33:0] exp_rsp[$];
    bit          hold_acc = 1'b0;
    bit          hold_rsp = 1'b0;
    logic [47:0] held_acc;
    logic [33:0] held_rsp;
    vec_t        vt[8];

    pu_or1k_spr_master #(.TIMEOUT(c_timeout)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_dat_i    (cmd_dat_i),
        .cmd_len_i    (cmd_len_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_last_o   (rsp_last_o),
        .spr_access_o (spr_access_o),
        .spr_we_o     (spr_we_o),
        .spr_re_o     (spr_re_o),
        .spr_addr_o   (spr_addr_o),
        .spr_dat_o    (spr_dat_o),
        .spr_bus_ack_i(spr_bus_ack_i),
        .spr_dat_i    (spr_dat_i)
    );

    always #5 clk = ~clk;

    // Slave acks after s_delay wait cycles; data is a function of the address
    assign spr_bus_ack_i = spr_access_o && !s_noack && (acc_cnt == s_delay);
    assign spr_dat_i     = spr_bus_ack_i ? {s_hi, spr_addr_o ^ 16'h6A34} : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst)                               acc_cnt <= 0;
        else if (spr_access_o && !spr_bus_ack_i) acc_cnt <= acc_cnt + 1;
        else                                   acc_cnt <= 0;
    end

    always @(posedge clk) begin
        #1;
        if (rmode == 0)      rsp_ready_i = 1'b1;
        else if (rmode == 1) rsp_ready_i = ~rsp_ready_i;
        else                 rsp_ready_i = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_extra(input string name, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected no activity (t=%0t)", name, act, $time);
    endtask

    function automatic logic [15:0] next_addr(input logic [15:0] a);
        return (a & 16'hF800) | ((a + 16'd1) & 16'h07FF);
    endfunction

    // Monitors sample on the falling edge, when DUT outputs are settled
    always @(negedge clk) begin
        if (rst) begin
            hold_acc = 1'b0;
            hold_rsp = 1'b0;
        end else begin
            if (spr_access_o) begin
                acc_cycles++;
                check("spr_qual", {spr_we_o, spr_re_o}, {cur_we, ~cur_we});
                if (cur_we) check("spr_wdat", spr_dat_o, cur_dat);
                if (hold_acc) check("spr_hold", {spr_addr_o, spr_dat_o}, held_acc);
                if (spr_bus_ack_i) begin
                    if (exp_addr.size() == 0) fail_extra("spr_extra_acc", spr_addr_o);
                    else check("spr_addr", spr_addr_o, exp_addr.pop_front());
                end
                hold_acc = !spr_bus_ack_i;
                held_acc = {spr_addr_o, spr_dat_o};
            end else begin
                check("spr_idle", {spr_we_o, spr_re_o}, 2'b00);
                hold_acc = 1'b0;
            end
            if (rsp_valid_o) begin
                if (hold_rsp) check("rsp_hold", {rsp_dat_o, rsp_err_o, rsp_last_o}, held_rsp);
                if (rsp_ready_i) begin
                    if (exp_rsp.size() == 0) fail_extra("rsp_extra", {rsp_dat_o, rsp_err_o, rsp_last_o});
                    else check("rsp_word", {rsp_dat_o, rsp_err_o, rsp_last_o}, exp_rsp.pop_front());
                end
                hold_rsp = !rsp_ready_i;
                held_rsp = {rsp_dat_o, rsp_err_o, rsp_last_o};
            end else begin
                hold_rsp = 1'b0;
            end
        end
    end

    task automatic issue(input vec_t v, input bit lat);
        logic [15:0] a;
        int          words;
        words      = v.we ? 1 : int'(v.len) + 1;
        s_delay    = v.delay;
        s_noack    = v.noack;
        s_hi       = v.hi;
        rmode      = v.rmode;
        cur_we     = v.we;
        cur_dat    = v.dat;
        acc_cycles = 0;
        a          = v.addr;
        if (v.noack) begin
            exp_rsp.push_back({32'h0, 1'b1, 1'b1});
        end else begin
            for (int k = 0; k < words; k++) begin
                exp_addr.push_back(a);
                exp_rsp.push_back({v.we ? 32'h0 : {v.hi, a ^ 16'h6A34}, 1'b0, (k == words - 1)});
                a = next_addr(a);
            end
        end
        cmd_we_i    = v.we;
        cmd_addr_i  = v.addr;
        cmd_dat_i   = v.dat;
        cmd_len_i   = v.len;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        // Keep offering a bogus command while busy; it must be ignored
        cmd_addr_i = 16'hDEAD;
        cmd_dat_i  = 32'hBAD0_BAD0;
        cmd_we_i   = ~v.we;
        cmd_len_i  = 3'd7;
        @(negedge clk);
        if (lat) check("lat_access", {spr_access_o, spr_re_o, spr_addr_o}, {1'b1, 1'b1, v.addr});
        @(negedge clk);
        if (lat) check("lat_rsp", {rsp_valid_o, spr_access_o}, 2'b10);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic finish_cmd(input vec_t v, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (cmd_ready_o && exp_rsp.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_extra({name, "_timeout"}, exp_rsp.size());
        check({name, "_acc_cycles"}, acc_cycles, v.exp_cyc);
        check({name, "_acc_left"}, exp_addr.size(), 0);
        exp_addr.delete();
        exp_rsp.delete();
    endtask

    initial begin
        bit   found;
        vec_t r;
        //          we    addr      dat           len   dly noack rmode hi        cyc
        vt[0] = '{1'b0, 16'h7800, 32'h0,        3'd0, 0,  1'b0, 0, 16'h0000,  1};
        vt[1] = '{1'b1, 16'h7808, 32'h0000_0401, 3'd0, 3,  1'b0, 0, 16'hBEEF,  4};
        vt[2] = '{1'b0, 16'h7800, 32'h0,        3'd7, 0,  1'b0, 1, 16'hC0DE,  8};
        vt[3] = '{1'b0, 16'h5000, 32'h0,        3'd3, 0,  1'b1, 1, 16'h0000, 15};
        vt[4] = '{1'b0, 16'h27FE, 32'h0,        3'd2, 1,  1'b0, 0, 16'hA5A5,  6};
        vt[5] = '{1'b0, 16'h07FF, 32'h0,        3'd1, 2,  1'b0, 2, 16'h1357,  6};
        vt[6] = '{1'b1, 16'h1234, 32'hCAFE_F00D, 3'd5, 0,  1'b0, 2, 16'h0000,  1};
        vt[7] = '{1'b0, 16'hF800, 32'h0,        3'd0, 14, 1'b0, 0, 16'hFFFF, 15};

        #3;
        check("rst_state", {cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o,
                            spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o},
              {1'b1, 86'b0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_rst", cmd_ready_o, 1'b1);

        for (int i = 0; i < 8; i++) begin
            issue(vt[i], i == 0);
            finish_cmd(vt[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset during the second word of a burst
        r = '{1'b0, 16'h4000, 32'h0, 3'd3, 1, 1'b0, 0, 16'h1111, 0};
        issue(r, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (spr_access_o && exp_addr.size() == 3) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_extra("midrst_no_2nd_word", exp_addr.size());
        #1 rst = 1'b1;
        #1;
        check("midrst_async", {cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o,
                               spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o},
              {1'b1, 86'b0});
        exp_addr.delete();
        exp_rsp.delete();
        repeat (2) @(posedge clk);
        #1 check("midrst_held", {cmd_ready_o, rsp_valid_o, spr_access_o}, 3'b100);
        rst = 1'b0;
        @(posedge clk);
        #1 check("midrst_ready", cmd_ready_o, 1'b1);
        issue(vt[4], 1'b0);
        finish_cmd(vt[4], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
